// File: rtl/comp_sched_pkg.sv
// Shared types and constants for the comparator scheduler: FSM state encoding,
// result flag bit positions and an index-width helper.
package comp_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StRsp  = 2'd2
    } state_e;

    localparam int unsigned NUM_FLAGS = 6;
    localparam int unsigned FLAG_LT   = 0;
    localparam int unsigned FLAG_LE   = 1;
    localparam int unsigned FLAG_GT   = 2;
    localparam int unsigned FLAG_GE   = 3;
    localparam int unsigned FLAG_EQ   = 4;
    localparam int unsigned FLAG_NE   = 5;

    // Keeps index ports at least one bit wide when only one requester exists.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comp_sched_rr_arb.sv
// Round-robin arbiter: scans upward from ptr with wrap-around and returns the
// first active requester as a one-hot grant plus its binary index.
module comp_sched_rr_arb
    import comp_sched_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    logic [IW-1:0] w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            w_cand = IW'((32'(ptr) + off) % NREQ);
            if (!grant_vld && req[w_cand]) begin
                grant_vld = 1'b1;
                grant_idx = w_cand;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/comp_sched.sv
// Shared fixed-point comparator: arbitrates NREQ requesters, aligns the two
// operands to a common exponent exactly, and returns six ordering flags.
module comp_sched
    import comp_sched_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned A_WIDTH = 16,
    parameter  int          A_EXP   = -8,
    parameter  int unsigned B_WIDTH = 17,
    parameter  int          B_EXP   = -9,
    localparam int unsigned IW      = idx_width(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*A_WIDTH-1:0]   req_a,
    input  logic [NREQ*B_WIDTH-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IW-1:0]             rsp_id,
    output logic [NUM_FLAGS-1:0]      rsp_flags
);

    localparam int EXP_MIN = (A_EXP < B_EXP) ? A_EXP : B_EXP;
    localparam int SA      = A_EXP - EXP_MIN;
    localparam int SB      = B_EXP - EXP_MIN;
    localparam int CW_A    = int'(A_WIDTH) + SA;
    localparam int CW_B    = int'(B_WIDTH) + SB;
    // Wide enough that the left shift never drops a significant bit.
    localparam int CW      = (CW_A > CW_B) ? CW_A : CW_B;

    state_e                     r_state;
    logic [IW-1:0]              r_ptr;
    logic signed [A_WIDTH-1:0]  r_a;
    logic signed [B_WIDTH-1:0]  r_b;
    logic [IW-1:0]              r_id;
    logic                       r_rsp_valid;
    logic [NUM_FLAGS-1:0]       r_rsp_flags;
    logic [IW-1:0]              r_rsp_id;

    logic [NREQ-1:0]            w_grant;
    logic [IW-1:0]              w_grant_idx;
    logic                       w_grant_vld;
    logic [IW-1:0]              w_ptr_nxt;
    logic [A_WIDTH-1:0]         w_sel_a;
    logic [B_WIDTH-1:0]         w_sel_b;
    logic signed [CW-1:0]       w_a_al;
    logic signed [CW-1:0]       w_b_al;
    logic                       w_lt;
    logic                       w_eq;
    logic [NUM_FLAGS-1:0]       w_flags;

    comp_sched_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign req_ready = (rst_n && (r_state == StIdle)) ? w_grant : '0;

    assign w_ptr_nxt = (w_grant_idx == IW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_sel_a   = req_a[w_grant_idx * A_WIDTH +: A_WIDTH];
    assign w_sel_b   = req_b[w_grant_idx * B_WIDTH +: B_WIDTH];

    assign w_a_al = CW'(r_a) <<< SA;
    assign w_b_al = CW'(r_b) <<< SB;
    assign w_lt   = (w_a_al < w_b_al);
    assign w_eq   = (w_a_al == w_b_al);

    always_comb begin
        w_flags          = '0;
        w_flags[FLAG_LT] = w_lt;
        w_flags[FLAG_LE] = w_lt | w_eq;
        w_flags[FLAG_GT] = ~(w_lt | w_eq);
        w_flags[FLAG_GE] = ~w_lt;
        w_flags[FLAG_EQ] = w_eq;
        w_flags[FLAG_NE] = ~w_eq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_flags <= '0;
            r_rsp_id    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_vld) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_grant_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= StCmp;
                    end
                end
                StCmp: begin
                    r_rsp_flags <= w_flags;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= StRsp;
                end
                StRsp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_flags = r_rsp_flags;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_comp_sched.sv
// Scoreboard bench for comp_sched: a value-level model predicts grants and flags,
// a negedge monitor checks every grant and response against it.
module tb_comp_sched;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int AE   = -8;
    localparam int BW   = 17;
    localparam int BE   = -9;
    localparam int IW   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_a;
    logic [NREQ*BW-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IW-1:0]        rsp_id;
    logic [5:0]           rsp_flags;

    always #5 clk = ~clk;

    comp_sched #(
        .NREQ    (NREQ),
        .A_WIDTH (AW),
        .A_EXP   (AE),
        .B_WIDTH (BW),
        .B_EXP   (BE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_flags (rsp_flags)
    );

    typedef struct {
        int         id;
        logic [5:0] flags;
        int         due;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    int   grant_log[$];
    bit   accepted[NREQ];
    bit   busy_m = 1'b0;
    int   ptr_m = 0;
    bit   rsp_seen = 1'b0;
    bit   rand_rdy = 1'b0;
    int   g_m;
    logic [NREQ-1:0] eg_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic real pow2(int e);
        real r = 1.0;
        if (e < 0) for (int k = 0; k < -e; k++) r = r / 2.0;
        else       for (int k = 0; k < e; k++)  r = r * 2.0;
        return r;
    endfunction

    // Flags straight from the real-valued operands: {ne, eq, ge, gt, le, lt}.
    function automatic logic [5:0] model_flags(int a, int b);
        real va, vb;
        va = a * pow2(AE);
        vb = b * pow2(BE);
        return {va != vb, va == vb, va >= vb, va > vb, va <= vb, va < vb};
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            sbq.delete();
            ptr_m    = 0;
            busy_m   = 1'b0;
            rsp_seen = 1'b0;
        end else begin
            g_m  = busy_m ? -1 : rr_pick(req_valid, ptr_m);
            eg_m = '0;
            if (g_m >= 0) eg_m[g_m] = 1'b1;
            chk("grant", 64'(req_ready), 64'(eg_m));
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k]) begin
                    accepted[k] = 1'b1;
                    grant_log.push_back(k);
                end
            end
            if (g_m >= 0) begin
                sbq.push_back('{id: g_m,
                                flags: model_flags(int'($signed(req_a[g_m*AW +: AW])),
                                                   int'($signed(req_b[g_m*BW +: BW]))),
                                due: cyc + 2});
                busy_m = 1'b1;
                ptr_m  = (g_m + 1) % NREQ;
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual id=%0d required=no response", rsp_id);
                end else begin
                    if (!rsp_seen) begin
                        chk("rsp_latency", 64'(cyc), 64'(sbq[0].due));
                        rsp_seen = 1'b1;
                    end
                    chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
                    chk("rsp_flags", 64'(rsp_flags), 64'(sbq[0].flags));
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        busy_m   = 1'b0;
                        rsp_seen = 1'b0;
                    end
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_rsp actual=no rsp_valid required=rsp for id %0d", sbq[0].id);
                void'(sbq.pop_front());
                busy_m   = 1'b0;
                rsp_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (accepted[i]) begin
                req_valid[i] = 1'b0;
                accepted[i]  = 1'b0;
            end
        end
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
        req_valid[i]      = 1'b1;
    endtask

    function automatic int rnd_a();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic fill_all();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) set_req(i, rnd_a(), int'($urandom_range(0, 131071)) - 65536);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((req_valid != '0 || sbq.size() != 0 || rsp_valid) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=still busy required=idle within 300 cycles");
        end
    endtask

    task automatic wait_grants(input int target, input bit refill);
        int n = 0;
        while (grant_log.size() < target && n < 100) begin
            if (refill) fill_all();
            tick();
            n++;
        end
        if (grant_log.size() < target) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=%0d grants required=%0d", grant_log.size(), target);
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int n;
        int order[5];
        int a;
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n  = 1'b1;
        rsp_ready = 1'b1;

        // Directed value cases: equal, lt, gt, and extremes
        set_req(0, 256, 512);     wait_idle();
        set_req(1, -128, 128);    wait_idle();
        set_req(2, 1, 1);         wait_idle();
        set_req(3, -32768, 65535); wait_idle();
        set_req(0, 32767, -65536); wait_idle();

        // All requesters held valid from a fresh pointer
        apply_reset(2);
        n0    = grant_log.size();
        order = '{0, 1, 2, 3, 0};
        wait_grants(n0 + 5, 1'b1);
        req_valid = '0;
        for (int t = 0; t < 5; t++) begin
            if (grant_log.size() > n0 + t) chk("rr_order", 64'(grant_log[n0 + t]), 64'(order[t]));
        end
        wait_idle();

        // Back-pressure on the response while other requests wait
        rsp_ready = 1'b0;
        set_req(2, 1000, -3);
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        set_req(1, 77, 154);
        set_req(3, -5, 4);
        repeat (5) tick();
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while the request sits in the compare state
        n0 = grant_log.size();
        set_req(1, 5, 7);
        wait_grants(n0 + 1, 1'b0);
        rst_n = 1'b0;
        tick();
        fill_all();
        tick();
        rst_n = 1'b1;
        n0 = grant_log.size();
        wait_grants(n0 + 1, 1'b0);
        if (grant_log.size() > n0) chk("post_reset_grant", 64'(grant_log[n0]), 64'd0);
        req_valid = '0;
        wait_idle();

        // Randomised traffic with random response back-pressure
        rand_rdy = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    a = rnd_a();
                    if ($urandom_range(0, 3) == 0) set_req(i, a, 2 * a);
                    else set_req(i, a, int'($urandom_range(0, 131071)) - 65536);
                end
            end
            tick();
        end
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=still running required=finish before 2ms");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
